// File: rtl/spi_frame_reader.sv
// Multi-frame SPI flash reader: issues one READ per frame and shifts each frame's
// data into a shared display buffer, either overwriting it or OR-compositing into it.
module spi_frame_reader #(
   parameter int         DATA_BITS  = 8192,
   parameter int         NUM_FRAMES = 3,
   parameter int         ADDR_BITS  = 24,
   parameter logic [7:0] CMD_READ   = 8'h03,
   parameter int         CS_GAP     = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            abort,
   input  logic                            merge_en,
   input  logic [NUM_FRAMES*ADDR_BITS-1:0] frame_addr,
   output logic                            busy,
   output logic                            done,
   output logic [3:0]                      frame_idx,
   output logic                            data_valid,
   output logic [DATA_BITS-1:0]            data,
   output logic                            spi_cs_n,
   output logic                            spi_sck,
   output logic                            spi_mosi,
   input  logic                            spi_miso
);

   localparam int CMD_BITS = 8 + ADDR_BITS;
   localparam int MAX_BITS = (CMD_BITS > DATA_BITS) ? CMD_BITS : DATA_BITS;
   localparam int CNT_W    = $clog2(MAX_BITS);
   localparam int GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);
   localparam logic [3:0]       LAST_IDX  = 4'(NUM_FRAMES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMD  = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 phase_q, phase_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [3:0]           frame_idx_q, frame_idx_d;
   logic [CMD_BITS-1:0]  cmd_sr_q, cmd_sr_d;
   logic                 merge_q, merge_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 data_valid_q, data_valid_d;
   logic                 cs_n_q, cs_n_d;
   logic                 sck_q, sck_d;
   logic                 mosi_q, mosi_d;

   logic [3:0]           next_idx;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [CMD_BITS-1:0]  load_word;
   logic                 load_frame;

   // Address of the frame about to start: frame 0 from IDLE, the following one from GAP
   always_comb begin
      next_idx = (state_q == GAP) ? frame_idx_q + 4'd1 : 4'd0;
      sel_addr = '0;
      for (int k = 0; k < NUM_FRAMES; k++) begin
         if (next_idx == 4'(k)) begin
            sel_addr = frame_addr[k*ADDR_BITS +: ADDR_BITS];
         end
      end
      load_word = {CMD_READ, sel_addr};
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      frame_idx_d  = frame_idx_q;
      cmd_sr_d     = cmd_sr_q;
      merge_d      = merge_q;
      data_d       = data_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      data_valid_d = data_valid_q;
      cs_n_d       = cs_n_q;
      sck_d        = sck_q;
      mosi_d       = mosi_q;
      load_frame   = 1'b0;

      if (abort) begin
         state_d = IDLE;
         phase_d = 1'b0;
         cs_n_d  = 1'b1;
         sck_d   = 1'b0;
         mosi_d  = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  load_frame   = 1'b1;
                  frame_idx_d  = 4'd0;
                  data_valid_d = 1'b0;
                  busy_d       = 1'b1;
               end
            end
            CMD: begin
               if (!phase_q) begin
                  sck_d   = 1'b1;
                  phase_d = 1'b1;
               end else begin
                  sck_d   = 1'b0;
                  phase_d = 1'b0;
                  if (bit_cnt_q == CMD_LAST) begin
                     state_d   = DATA;
                     bit_cnt_d = '0;
                     mosi_d    = 1'b0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     mosi_d    = cmd_sr_q[CMD_BITS-1];
                     cmd_sr_d  = cmd_sr_q << 1;
                  end
               end
            end
            DATA: begin
               if (!phase_q) begin
                  sck_d   = 1'b1;
                  phase_d = 1'b1;
               end else begin
                  sck_d   = 1'b0;
                  phase_d = 1'b0;
                  // The bit leaving the MSB lines up with the same bit position of the new frame
                  data_d  = {data_q[DATA_BITS-2:0],
                             spi_miso | (merge_q && (frame_idx_q != 4'd0) && data_q[DATA_BITS-1])};
                  if (bit_cnt_q == DATA_LAST) begin
                     bit_cnt_d = '0;
                     cs_n_d    = 1'b1;
                     if (frame_idx_q == LAST_IDX) begin
                        state_d      = IDLE;
                        done_d       = 1'b1;
                        data_valid_d = 1'b1;
                        busy_d       = 1'b0;
                     end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  load_frame  = 1'b1;
                  frame_idx_d = next_idx;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         // Frame entry: latch address and merge mode, drop CS and present the first opcode bit
         if (load_frame) begin
            state_d   = CMD;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            cs_n_d    = 1'b0;
            sck_d     = 1'b0;
            mosi_d    = load_word[CMD_BITS-1];
            cmd_sr_d  = load_word << 1;
            merge_d   = merge_en;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         phase_q      <= 1'b0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         frame_idx_q  <= 4'd0;
         cmd_sr_q     <= '0;
         merge_q      <= 1'b0;
         data_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         data_valid_q <= 1'b0;
         cs_n_q       <= 1'b1;
         sck_q        <= 1'b0;
         mosi_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         frame_idx_q  <= frame_idx_d;
         cmd_sr_q     <= cmd_sr_d;
         merge_q      <= merge_d;
         data_q       <= data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         data_valid_q <= data_valid_d;
         cs_n_q       <= cs_n_d;
         sck_q        <= sck_d;
         mosi_q       <= mosi_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign frame_idx  = frame_idx_q;
   assign data_valid = data_valid_q;
   assign data       = data_q;
   assign spi_cs_n   = cs_n_q;
   assign spi_sck    = sck_q;
   assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader with a small SPI flash model on the bus.
module tb_spi_frame_reader;

   localparam int DATA_BITS  = 16;
   localparam int NUM_FRAMES = 3;
   localparam int ADDR_BITS  = 24;
   localparam int CS_GAP     = 4;

   logic                            clk;
   logic                            rst_n;
   logic                            start;
   logic                            abort;
   logic                            merge_en;
   logic [NUM_FRAMES*ADDR_BITS-1:0] frame_addr;
   logic                            busy;
   logic                            done;
   logic [3:0]                      frame_idx;
   logic                            data_valid;
   logic [DATA_BITS-1:0]            data;
   logic                            spi_cs_n;
   logic                            spi_sck;
   logic                            spi_mosi;
   logic                            spi_miso;

   int nVectors = 0;
   int nFails   = 0;
   int cyc      = 0;
   int pulseAt  = 0;
   int doneCount = 0;
   int gapRun   = 0;
   int bitNum   = 0;
   int n        = 0;
   logic [31:0] cmdWord;
   logic [15:0] curWord;
   logic [31:0] cmdLog[$];
   int          gapLog[$];

   spi_frame_reader #(
      .DATA_BITS (DATA_BITS),
      .NUM_FRAMES(NUM_FRAMES),
      .ADDR_BITS (ADDR_BITS),
      .CMD_READ  (8'h03),
      .CS_GAP    (CS_GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .merge_en  (merge_en),
      .frame_addr(frame_addr),
      .busy      (busy),
      .done      (done),
      .frame_idx (frame_idx),
      .data_valid(data_valid),
      .data      (data),
      .spi_cs_n  (spi_cs_n),
      .spi_sck   (spi_sck),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flash contents: three image words at 0x100/0x200/0x300, elsewhere byte = addr[7:0]
   function automatic logic [15:0] wordFor(input logic [23:0] a);
      case (a)
         24'h000100: wordFor = 16'hF000;
         24'h000200: wordFor = 16'h0F00;
         24'h000300: wordFor = 16'h00F0;
         default:    wordFor = {a[7:0], a[7:0] + 8'd1};
      endcase
   endfunction

   // Flash model: captures opcode+address, then presents data during each sck-high phase
   initial begin
      spi_miso = 1'b0;
      cmdWord  = '0;
      curWord  = '0;
      forever begin
         @(negedge clk);
         if (spi_cs_n) begin
            bitNum = 0;
         end else if (spi_sck) begin
            if (bitNum < 32) begin
               cmdWord = {cmdWord[30:0], spi_mosi};
               if (bitNum == 31) cmdLog.push_back(cmdWord);
            end else if (bitNum < 48) begin
               curWord  = wordFor(cmdWord[23:0]);
               spi_miso = curWord[47-bitNum];
            end
            bitNum++;
         end
      end
   end

   // Bus monitors: done pulses and inter-frame chip-select high time
   initial begin
      forever begin
         @(negedge clk);
         if (done) doneCount++;
         if (busy && spi_cs_n) begin
            gapRun++;
         end else begin
            if (gapRun > 0) gapLog.push_back(gapRun);
            gapRun = 0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nVectors++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_FRAMES*ADDR_BITS-1:0] addrs, input logic merge);
      @(negedge clk);
      frame_addr = addrs;
      merge_en   = merge;
      start      = 1'b1;
      cyc        = 0;
      doneCount  = 0;
      cmdLog.delete();
      gapLog.delete();
   endtask

   task automatic stepCycles(input int count);
      repeat (count) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 1) start = 1'b0;
         if (pulseAt > 0 && cyc == pulseAt) start = 1'b1;
         if (pulseAt > 0 && cyc == pulseAt + 1) start = 1'b0;
      end
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (cyc < 600) begin
         stepCycles(1);
         if (done) begin
            cycles = cyc;
            break;
         end
      end
      if (cycles == 0) cycles = -1;
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      merge_en   = 1'b0;
      frame_addr = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset and idle
      repeat (20) @(negedge clk);
      checkOutput("idle_cs_n", 32'(spi_cs_n), 32'd1);
      checkOutput("idle_sck", 32'(spi_sck), 32'd0);
      checkOutput("idle_mosi", 32'(spi_mosi), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_data", 32'(data), 32'd0);
      checkOutput("idle_valid", 32'(data_valid), 32'd0);
      checkOutput("idle_frame_idx", 32'(frame_idx), 32'd0);
      checkOutput("idle_done_count", 32'(doneCount), 32'd0);

      // Command framing, gap timing, done latency, overwrite of incrementing bytes
      applyStimulus({24'h000030, 24'h000020, 24'h000010}, 1'b0);
      stepCycles(1);
      checkOutput("start_cs_low", 32'(spi_cs_n), 32'd0);
      checkOutput("start_busy", 32'(busy), 32'd1);
      waitDone(n);
      checkOutput("t2_done_cycle", 32'(n), 32'd297);
      checkOutput("t2_busy_at_done", 32'(busy), 32'd0);
      checkOutput("t2_valid", 32'(data_valid), 32'd1);
      checkOutput("t2_data", 32'(data), 32'h3031);
      checkOutput("t2_cmd_count", 32'(cmdLog.size()), 32'd3);
      checkOutput("t2_cmd0", cmdLog[0], 32'h03000010);
      checkOutput("t2_cmd1", cmdLog[1], 32'h03000020);
      checkOutput("t2_cmd2", cmdLog[2], 32'h03000030);
      checkOutput("t2_gap_count", 32'(gapLog.size()), 32'd2);
      checkOutput("t2_gap0", 32'(gapLog[0]), 32'd4);
      checkOutput("t2_gap1", 32'(gapLog[1]), 32'd4);
      stepCycles(1);
      checkOutput("t2_done_one_cycle", 32'(done), 32'd0);

      // Overwrite: last image word wins
      applyStimulus({24'h000300, 24'h000200, 24'h000100}, 1'b0);
      waitDone(n);
      checkOutput("t3_done_cycle", 32'(n), 32'd297);
      checkOutput("t3_data", 32'(data), 32'h00F0);
      checkOutput("t3_valid", 32'(data_valid), 32'd1);

      // Merge, with a stray start pulse mid-transaction
      pulseAt = 50;
      applyStimulus({24'h000300, 24'h000200, 24'h000100}, 1'b1);
      waitDone(n);
      pulseAt = 0;
      checkOutput("t4_done_cycle", 32'(n), 32'd297);
      checkOutput("t4_data", 32'(data), 32'hFFF0);
      stepCycles(400);
      checkOutput("t4_single_done", 32'(doneCount), 32'd1);

      // Abort two bits into frame 1 data: F000 shifted by two zero bits
      applyStimulus({24'h000300, 24'h000200, 24'h000100}, 1'b0);
      stepCycles(170);
      checkOutput("t5_frame_idx", 32'(frame_idx), 32'd1);
      checkOutput("t5_cs_before_abort", 32'(spi_cs_n), 32'd0);
      abort = 1'b1;
      stepCycles(1);
      abort = 1'b0;
      checkOutput("t5_abort_cs", 32'(spi_cs_n), 32'd1);
      checkOutput("t5_abort_sck", 32'(spi_sck), 32'd0);
      checkOutput("t5_abort_busy", 32'(busy), 32'd0);
      checkOutput("t5_partial_data", 32'(data), 32'hC000);
      stepCycles(400);
      checkOutput("t5_no_done", 32'(doneCount), 32'd0);
      checkOutput("t5_valid_low", 32'(data_valid), 32'd0);

      // Abort and start together in IDLE: nothing starts
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      checkOutput("t5_abort_wins_busy", 32'(busy), 32'd0);
      checkOutput("t5_abort_wins_cs", 32'(spi_cs_n), 32'd1);

      // Restart after abort completes normally
      applyStimulus({24'h000300, 24'h000200, 24'h000100}, 1'b1);
      waitDone(n);
      checkOutput("t5_restart_done_cycle", 32'(n), 32'd297);
      checkOutput("t5_restart_data", 32'(data), 32'hFFF0);

      // Async reset in the middle of frame 0 data
      applyStimulus({24'h000300, 24'h000200, 24'h000100}, 1'b1);
      stepCycles(80);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_cs", 32'(spi_cs_n), 32'd1);
      checkOutput("t6_rst_sck", 32'(spi_sck), 32'd0);
      checkOutput("t6_rst_mosi", 32'(spi_mosi), 32'd0);
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      checkOutput("t6_rst_done", 32'(done), 32'd0);
      checkOutput("t6_rst_valid", 32'(data_valid), 32'd0);
      checkOutput("t6_rst_frame_idx", 32'(frame_idx), 32'd0);
      checkOutput("t6_rst_data", 32'(data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
      $finish;
   end

endmodule
